input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
// Conditions raw player controls (KEY[3:1] for player 1, GPIO[5]/[3]/[1] for player 2)
// before they reach the player modules. Per channel: two-flop synchroniser, polarity fix,
// counter debounce, single-cycle press pulse, and a frame-aligned sticky press flag so a
// tap shorter than one game frame is never lost. Runs on the fast clock; samples at frame_tick.
// PARAMETERS
// N_CH             6       number of control channels
// DEBOUNCE_CYCLES  250000  clk cycles raw level must hold before accepted (5 ms @ 50 MHz), >=2
// CNT_W            18      debounce counter width, 2^CNT_W > DEBOUNCE_CYCLES
// ACTIVE_LOW       1       1: raw_in low = pressed (KEY/GPIO); 0: raw_in high = pressed
// PORTS
// clk            in   1     system clock (CLOCK_50 domain)
// rst            in   1     asynchronous reset, active-high
// raw_in         in   N_CH  unsynchronised button/GPIO levels
// frame_tick     in   1     1-cycle strobe once per game frame, synchronous to clk
// stable_o       out  N_CH  debounced level, 1 = pressed
// press_pulse_o  out  N_CH  1-cycle pulse when stable_o rises
// frame_level_o  out  N_CH  stable_o sampled at frame_tick, held for the frame
// frame_press_o  out  N_CH  1 for the whole frame if any press occurred in previous frame
// BEHAVIOUR
// - Reset (async, rst=1): sync flops load the inactive raw level (1 if ACTIVE_LOW, else 0);
//   counters 0; stable_o, press_pulse_o, frame_level_o, frame_press_o, press_acc all 0.
//   A button held through reset is seen as a fresh press after release of rst + debounce.
// - Sync: s1<=raw_in; s2<=s1; lvl = ACTIVE_LOW ? ~s2 : s2. Channels fully independent.
// - Debounce per channel: if lvl==stable: cnt<=0.
//   else if cnt==DEBOUNCE_CYCLES-1: stable<=lvl, cnt<=0. else cnt<=cnt+1.
//   stable_o toggles on the DEBOUNCE_CYCLES-th clk edge of lvl continuously differing;
//   total raw->stable_o latency = DEBOUNCE_CYCLES+2 edges. Any return of lvl to stable
//   before that restarts the count (glitch rejected). Counter never wraps.
// - press_pulse_o: registered, high exactly 1 cycle, the cycle after stable_o goes 0->1.
//   No pulse on 1->0. Back-to-back presses give one pulse each.
// - press_acc[i] (internal sticky): set by press_pulse_o[i]; cleared at frame_tick.
// - On frame_tick edge: frame_level_o<=stable_o;
//   frame_press_o<=press_acc|press_pulse_o (pulse coincident with tick counts for the
//   closing frame, not carried); press_acc<=0. frame_* outputs change only on frame_tick.
// - Multiple presses within one frame collapse to a single frame_press_o=1.
// - frame_tick held high >1 cycle: each high cycle acts as a tick (second clears flag).
// - Reset mid-debounce or mid-frame: all state discarded, no pending press survives.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, N_CH=6, ACTIVE_LOW=1)
// 1 rst pulse, raw_in=6'h3F -> all outputs 0; raw_in[0]=0 held -> stable_o[0]=1 exactly
//   6 edges after change, press_pulse_o[0]=1 for one cycle next edge, others stay 0.
// 2 raw_in[1] low 3 cycles then high -> stable_o[1], press_pulse_o[1] never assert.
// 3 raw_in[2] bounces 0/1/0/1 each cycle then low steady -> one stable rise, one pulse,
//   timed from the last bounce.
// 4 two full presses of ch3 between ticks -> next frame_tick: frame_press_o[3]=1 for that
//   frame only; following tick with no press -> 0.
// 5 press pulse in same cycle as frame_tick -> frame_press_o=1 that frame, 0 the next.
// 6 rst asserted while ch4 count=2 and press_acc[5]=1 -> outputs 0 asynchronously;
//   after release with raw_in high, no pulse or frame_press_o ever seen.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: conditions raw player controls before they reach the player logic.
// Each channel goes through a two-flop synchroniser, a polarity fix, a counter debounce and
// a rising-edge press pulse. Two frame-aligned views are also kept: the debounced level as
// it stood at the last frame_tick, and a sticky flag that catches any press during the
// previous frame, so a tap shorter than one frame is not lost.

module input_conditioner #(
    parameter int N_CH            = 6,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    input  logic            frame_tick,
    output logic [N_CH-1:0] stable_o,
    output logic [N_CH-1:0] press_pulse_o,
    output logic [N_CH-1:0] frame_level_o,
    output logic [N_CH-1:0] frame_press_o
);

    // Raw level that means "released"; the synchroniser resets to it so that a button
    // held through reset is seen as a fresh press once reset is released.
    localparam logic [N_CH-1:0]  IDLE_RAW = {N_CH{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  sync_1;
    logic [N_CH-1:0]  sync_2;
    logic [N_CH-1:0]  lvl;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  stable_d;
    logic [N_CH-1:0]  press_acc;

    // Two-flop synchroniser for the asynchronous button/GPIO inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= IDLE_RAW;
            sync_2 <= IDLE_RAW;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // 1 = pressed, regardless of the board's electrical polarity
    assign lvl = sync_2 ^ IDLE_RAW;

    // Debounce: accept a new level only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive clocks; any return to the accepted level restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_o <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (lvl[i] == stable_o[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_o[i] <= lvl[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered one-cycle pulse in the cycle after stable_o rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d      <= '0;
            press_pulse_o <= '0;
        end else begin
            stable_d      <= stable_o;
            press_pulse_o <= stable_o & ~stable_d;
        end
    end

    // Frame sampling: a pulse coincident with the tick belongs to the closing frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_acc     <= '0;
            frame_level_o <= '0;
            frame_press_o <= '0;
        end else if (frame_tick) begin
            frame_level_o <= stable_o;
            frame_press_o <= press_acc | press_pulse_o;
            press_acc     <= '0;
        end else begin
            press_acc <= press_acc | press_pulse_o;
        end
    end

endmodule
